// File: rtl/hilo_md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair and the pipeline stall handshake.
// Optional feature macro HILO_MADD_EN: op 111 becomes signed multiply-accumulate into {hi,lo}.
module hilo_md_unit #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef HILO_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b111;
`endif

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, FINISH} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;

   logic               accept, is_mul, is_div, signed_op, b_zero, mul_last, div_last;
   logic [2*WIDTH-1:0] a_ext, b_ext, product;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     rem_shift, trial;

   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   quo_q, rem_q, dsr_q;
   logic               quo_neg_q, rem_neg_q, dbz_q;
`ifdef HILO_MADD_EN
   logic               madd_q;
`endif

`ifdef HILO_MADD_EN
   assign is_mul    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
   assign signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
`else
   assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
   assign signed_op = (op == OP_MULT) || (op == OP_DIV);
`endif
   assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
   assign b_zero   = (src_b == '0);
   assign accept   = op_valid && !cancel && (state == IDLE);
   assign mul_last = (state == MUL_WAIT) && (cnt == CNT_W'(MUL_LAT - 1));
   assign div_last = (state == DIV_RUN) && (cnt == CNT_W'(WIDTH - 1));

   // Low 2*WIDTH bits of the extended product are exact for both signed and unsigned operands.
   assign a_ext   = {{WIDTH{signed_op & src_a[WIDTH-1]}}, src_a};
   assign b_ext   = {{WIDTH{signed_op & src_b[WIDTH-1]}}, src_b};
   assign product = a_ext * b_ext;

   assign mag_a = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
   assign mag_b = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

   assign rem_shift = {rem_q, quo_q[WIDTH-1]};
   assign trial     = rem_shift - {1'b0, dsr_q};

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt = state;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept && is_mul)      state_nxt = MUL_WAIT;
            else if (accept && is_div) state_nxt = b_zero ? FINISH : DIV_RUN;
         end
         MUL_WAIT: if (mul_last) state_nxt = IDLE;
         DIV_RUN:  if (div_last) state_nxt = FINISH;
         FINISH:   state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (cancel) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
         state <= state_nxt;
         if (state_nxt != state)                        cnt <= '0;
         else if (state == MUL_WAIT || state == DIV_RUN) cnt <= cnt + CNT_W'(1);
      end
   end

   // NOTE: working registers carry no reset; they are always loaded on accept before being read.
   always_ff @(posedge clk) begin
      if (accept && is_mul) begin
         prod_q <= product;
`ifdef HILO_MADD_EN
         madd_q <= (op == OP_MADD);
`endif
      end
      if (accept && is_div) begin
         quo_q     <= mag_a;
         dsr_q     <= mag_b;
         rem_q     <= '0;
         quo_neg_q <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
         rem_neg_q <= signed_op & src_a[WIDTH-1];
         dbz_q     <= b_zero;
      end
      if (state == DIV_RUN) begin
         quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
         rem_q <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         if (accept && op == OP_MTHI) hi <= src_a;
         if (accept && op == OP_MTLO) lo <= src_a;
         if (mul_last && !cancel) begin
            done <= 1'b1;
`ifdef HILO_MADD_EN
            {hi, lo} <= madd_q ? ({hi, lo} + prod_q) : prod_q;
`else
            {hi, lo} <= prod_q;
`endif
         end
         // Sign fixup: quotient truncates toward zero, remainder follows the dividend.
         if (state == FINISH && !cancel) begin
            done <= 1'b1;
            if (dbz_q) begin
               div_by_zero <= 1'b1;
            end else begin
               lo <= quo_neg_q ? -quo_q : quo_q;
               hi <= rem_neg_q ? -rem_q : rem_q;
            end
         end
      end
   end
endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Parametrised multiply/divide execution unit. Owns the HI/LO register pair and the stall handshake.
- Sits in the EX stage beside the ALU and is driven by the decoded md op and the HIwrite/LOwrite intent from the controller.
- Generalises the single-cycle HI/LO write path to multi-cycle signed and unsigned MULT and DIV, with configurable width and multiply latency, cancel, and divide-by-zero flagging.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4.
- MUL_LAT, 2, multiply latency in cycles from accept to HI/LO update; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- op_valid  in  1  op request this cycle.
- op  in  3  encoding: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD (macro-dependent).
- src_a  in  WIDTH  rs operand (dividend / multiplicand / MT source).
- src_b  in  WIDTH  rt operand (divisor / multiplier).
- cancel  in  1  exception flush; aborts an in-flight op.
- busy  out  1  stall request to the pipeline.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  one-cycle flag, coincident with done.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: while resetn is low at a clock edge, all outputs go to 0, the FSM goes to IDLE and all counters clear. Reset overrides everything, including a mid-operation DIV.
- Accept rule: an op is accepted at edge E0 only if op_valid=1, busy=0 and cancel=0. When busy=1, op_valid is ignored and upstream must hold the op.
- States: IDLE, MUL_WAIT, DIV_RUN, FINISH.
- MTHI / MTLO: handled in IDLE. hi (or lo) takes src_a at E0. No busy, no done.
- MULT / MULTU:
  - Full 2*WIDTH product captured at E0; state goes to MUL_WAIT.
  - busy=1 for MUL_LAT cycles.
  - At edge E_MUL_LAT: {hi,lo} gets the product, busy returns to 0 and done=1 for one cycle.
  - MULT is signed, MULTU is unsigned.
- DIV / DIVU, divisor nonzero:
  - At E0, capture operand magnitudes (signed op) or raw values (unsigned op), plus the sign info; enter DIV_RUN.
  - Restoring division, one quotient bit per cycle, WIDTH iterations; then FINISH applies the sign fixup.
  - hi/lo update at E_(WIDTH+1), where busy drops and done pulses. busy is high for WIDTH+1 cycles.
  - lo = quotient, truncated toward zero; quotient is negated when the operand signs differ.
  - hi = remainder, carrying the sign of the dividend.
  - Minimum-negative / -1: lo = 0x80..0 (wraps), hi = 0.
- DIV / DIVU, divisor zero: state goes to FINISH at E0 with busy=1 for one cycle. At E1, done=1 and div_by_zero=1; hi/lo are unchanged.
- cancel:
  - While busy=1: the FSM returns to IDLE at the next edge. No done, hi/lo unchanged, busy drops after that edge.
  - In the cycle where a result would commit: cancel wins and no commit occurs.
  - In IDLE: a coincident op (including MTHI/MTLO) is dropped.
- Back-to-back: busy=0 in the done cycle, so a new op may be accepted at the edge ending that cycle.
- op=000 and any op with op_valid=0: no effect.
- Counter widths: $clog2 sizing. The counter must not wrap for MUL_LAT=1 or for WIDTH iterations.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined: op 111 = MADD, signed. {hi,lo} is read at the commit edge and becomes {hi,lo} + signed product, modulo 2^(2*WIDTH). Timing and cancel behaviour are identical to MULT.
- Undefined: op 111 is never accepted. No busy, no done, hi/lo untouched. No accumulator adder is synthesised.

Test Plan (WIDTH=32, MUL_LAT=2):
- MULT a=0xFFFFFFFE, b=3 -> busy for 2 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle. Then MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000; div_by_zero=0.
- Preload hi=0xAA via MTHI, then DIVU a=7, b=0 -> done and div_by_zero pulse at E1; hi=0xAA, lo unchanged.
- DIV started, cancel asserted at cycle 10 -> busy=0 next cycle, no done, hi/lo unchanged. MTHI 0x1234 on the following cycle -> hi=0x1234. Also: resetn low mid-DIV -> all outputs 0.
- HILO_MADD_EN defined: MTLO 5, MTHI 0, then MADD a=2, b=3 -> lo=11, hi=0. With the macro undefined, the same op 111 -> busy stays 0, lo stays 5.
